mode_sequencer: RTL

- Parametrised one-hot display/setting mode sequencer for the digital clock top level.
- Steps forward or backward through NUM_MODES modes on button edges, gated by MAIN_STATE_ACTIVE.
- Returns automatically to the home mode after an idle timeout counted in TICK pulses.
- Outputs the one-hot mode vector, its binary index, and a one-cycle change strobe for downstream display muxes.

---
 rtl/mode_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/mode_sequencer.sv
// One-hot mode sequencer: steps through NUM_MODES modes on button edges and
// falls back to HOME_MODE after an idle timeout counted in TICK pulses.
module mode_sequencer #(
  parameter int NUM_MODES     = 7,
  parameter int HOME_MODE     = 0,
  parameter int TIMEOUT_TICKS = 30,
  localparam int IDX_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1,
  localparam int CNT_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 MODE_NEXT,
  input  logic                 MODE_PREV,
  input  logic                 MAIN_STATE_ACTIVE,
  input  logic                 TICK,
  output logic [NUM_MODES-1:0] CURRENT_STATE,
  output logic [IDX_W-1:0]     MODE_IDX,
  output logic                 MODE_CHANGED
);

  localparam logic [NUM_MODES-1:0] ONE_HOT0  = {{(NUM_MODES-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]     HOME_IDX  = IDX_W'(HOME_MODE);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_MODES - 1);
  localparam logic [CNT_W-1:0]     LAST_TICK = CNT_W'(TIMEOUT_TICKS - 1);

  logic [NUM_MODES-1:0] state_q, state_d;
  logic [IDX_W-1:0]     mode_idx_q, mode_idx_d;
  logic                 changed_q, changed_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 nxt_q, nxt_d;
  logic                 prv_q, prv_d;

  logic fwd, bwd, legal;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ONE_HOT0 << HOME_IDX;
      mode_idx_q <= HOME_IDX;
      changed_q  <= 1'b0;
      cnt_q      <= '0;
      nxt_q      <= 1'b0;
      prv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_idx_q <= mode_idx_d;
      changed_q  <= changed_d;
      cnt_q      <= cnt_d;
      nxt_q      <= nxt_d;
      prv_q      <= prv_d;
    end
  end

  // The register width equals NUM_MODES, so a single set bit is always in range.
  always_comb begin
    nxt_d      = MODE_NEXT;
    prv_d      = MODE_PREV;
    fwd        = MODE_NEXT & ~nxt_q;
    bwd        = MODE_PREV & ~prv_q;
    legal      = (state_q != '0) && ((state_q & (state_q - ONE_HOT0)) == '0);
    mode_idx_d = mode_idx_q;
    cnt_d      = cnt_q;
    if (!legal) begin
      mode_idx_d = HOME_IDX;
      cnt_d      = '0;
    end else if (MAIN_STATE_ACTIVE) begin
      if (fwd && !bwd) begin
        mode_idx_d = (mode_idx_q == LAST_IDX) ? '0 : mode_idx_q + 1'b1;
        cnt_d      = '0;
      end else if (bwd && !fwd) begin
        mode_idx_d = (mode_idx_q == '0) ? LAST_IDX : mode_idx_q - 1'b1;
        cnt_d      = '0;
      end else if (!fwd && (TIMEOUT_TICKS > 0)) begin
        // Simultaneous edges leave the counter untouched; otherwise idle-count.
        if (mode_idx_q == HOME_IDX) begin
          cnt_d = '0;
        end else if (TICK) begin
          if (cnt_q == LAST_TICK) begin
            mode_idx_d = HOME_IDX;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end
    state_d   = ONE_HOT0 << mode_idx_d;
    changed_d = (state_d != state_q);
  end

  always_comb begin
    CURRENT_STATE = state_q;
    MODE_IDX      = mode_idx_q;
    MODE_CHANGED  = changed_q;
  end

endmodule
